// File: rtl/fake_n64_cmd_sequencer.sv
// Command sequencer for a fake N64 accessory: synchronises the receiver handoff,
// decodes the command, waits out the line turnaround and supervises the response.
module fake_n64_cmd_sequencer #(
    parameter int TURN_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GUARD_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_handoff,
    input  logic [7:0]  cmd,
    input  logic [15:0] address,
    input  logic        tx_done,
    output logic        cur_operation,
    output logic        tx_start,
    output logic [5:0]  tx_len,
    output logic [7:0]  tx_cmd,
    output logic [15:0] pak_addr,
    output logic        write_commit,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun_err,
    output logic [7:0]  bad_cmd_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        TURN,
        TX,
        GUARD
    } state_t;

    localparam logic [15:0] TURN_LOAD    = 16'(TURN_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GUARD_LOAD   = 16'(GUARD_CYCLES - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  sync_q;
    logic        cur_op_q;
    logic        commit_q;
    logic [5:0]  tx_len_q;
    logic [7:0]  tx_cmd_q;
    logic [15:0] pak_addr_q;
    logic        timeout_q;
    logic        overrun_q;
    logic [7:0]  bad_cnt_q;
    logic        cmd_evt;

    // sync_q[1:0] is the synchroniser, sync_q[2] the history flop
    assign cmd_evt = sync_q[2] ^ sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sync_q     <= '0;
            cur_op_q   <= 1'b0;
            commit_q   <= 1'b0;
            tx_len_q   <= '0;
            tx_cmd_q   <= 8'hfe;
            pak_addr_q <= '0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            bad_cnt_q  <= '0;
        end else begin
            sync_q   <= {sync_q[1:0], rx_handoff};
            commit_q <= 1'b0;

            if (cmd_evt && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (cmd_evt) begin
                        tx_cmd_q   <= cmd;
                        pak_addr_q <= address & 16'hffe0;
                        state_q    <= DECODE;
                    end
                end

                DECODE: begin
                    state_q <= TURN;
                    cnt_q   <= TURN_LOAD;
                    case (tx_cmd_q)
                        8'h00, 8'hff: tx_len_q <= 6'd3;
                        8'h01:        tx_len_q <= 6'd4;
                        8'h02:        tx_len_q <= 6'd33;
                        8'h03:        tx_len_q <= 6'd1;
                        default: begin
                            if (bad_cnt_q != 8'hff) begin
                                bad_cnt_q <= bad_cnt_q + 8'd1;
                            end
                            state_q <= IDLE;
                        end
                    endcase
                end

                TURN: begin
                    if (cnt_q == '0) begin
                        cur_op_q <= 1'b1;
                        cnt_q    <= TIMEOUT_LOAD;
                        state_q  <= TX;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                TX: begin
                    // tx_done wins over a coincident timeout
                    if (tx_done) begin
                        commit_q <= (tx_cmd_q == 8'h03);
                        cnt_q    <= GUARD_LOAD;
                        state_q  <= GUARD;
                    end else if (cnt_q == '0) begin
                        timeout_q <= 1'b1;
                        cnt_q     <= GUARD_LOAD;
                        state_q   <= GUARD;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                GUARD: begin
                    if (cnt_q == '0) begin
                        cur_op_q <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // tx_start is decoded from registered state so it sits in the last TURN cycle
    assign tx_start      = (state_q == TURN) && (cnt_q == '0);
    assign cur_operation = cur_op_q;
    assign write_commit  = commit_q;
    assign tx_len        = tx_len_q;
    assign tx_cmd        = tx_cmd_q;
    assign pak_addr      = pak_addr_q;
    assign busy          = (state_q != IDLE);
    assign timeout_err   = timeout_q;
    assign overrun_err   = overrun_q;
    assign bad_cmd_cnt   = bad_cnt_q;

endmodule

// File: tb/tb_fake_n64_cmd_sequencer.sv
// Self-checking bench for fake_n64_cmd_sequencer: expected responses are queued
// when a command is sent and compared when tx_start fires.
module tb_fake_n64_cmd_sequencer;

    localparam int TURN = 4;
    localparam int TMO  = 40;
    localparam int GRD  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_handoff = 1'b0;
    logic [7:0]  cmd = '0;
    logic [15:0] address = '0;
    logic        tx_done = 1'b0;
    logic        cur_operation;
    logic        tx_start;
    logic [5:0]  tx_len;
    logic [7:0]  tx_cmd;
    logic [15:0] pak_addr;
    logic        write_commit;
    logic        busy;
    logic        timeout_err;
    logic        overrun_err;
    logic [7:0]  bad_cmd_cnt;

    typedef struct packed {
        logic [5:0]  len;
        logic [7:0]  cmd;
        logic [15:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_start  = 0;
    int   n_commit = 0;

    fake_n64_cmd_sequencer #(
        .TURN_CYCLES   (TURN),
        .TIMEOUT_CYCLES(TMO),
        .GUARD_CYCLES  (GRD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_handoff   (rx_handoff),
        .cmd          (cmd),
        .address      (address),
        .tx_done      (tx_done),
        .cur_operation(cur_operation),
        .tx_start     (tx_start),
        .tx_len       (tx_len),
        .tx_cmd       (tx_cmd),
        .pak_addr     (pak_addr),
        .write_commit (write_commit),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .overrun_err  (overrun_err),
        .bad_cmd_cnt  (bad_cmd_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_start)     n_start  <= n_start + 1;
        if (write_commit) n_commit <= n_commit + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [15:0] a);
        cmd        = c;
        address    = a;
        rx_handoff = ~rx_handoff;
    endtask

    task automatic push_exp(input logic [5:0] len, input logic [7:0] c, input logic [15:0] a);
        exp_t e;
        e.len  = len;
        e.cmd  = c;
        e.addr = a;
        sb_q.push_back(e);
    endtask

    // Waits (bounded) for tx_start, returns edges waited, and scores the response
    task automatic wait_start(output int n);
        exp_t e;
        n = 0;
        while ((tx_start !== 1'b1) && (n < 200)) begin
            tick();
            n++;
        end
        check("start_seen", tx_start, 1);
        check("sb_pending", sb_q.size() != 0, 1);
        if ((tx_start === 1'b1) && (sb_q.size() != 0)) begin
            e = sb_q.pop_front();
            check("tx_len", tx_len, e.len);
            check("tx_cmd", tx_cmd, e.cmd);
            check("pak_addr", pak_addr, e.addr);
            check("busy_turn", busy, 1);
        end
    endtask

    // Called in the tx_start cycle: completes the transfer with tx_done and guard
    task automatic finish_tx(input logic commit_exp);
        int c0;
        tick();
        check("cur_op_tx", cur_operation, 1);
        check("start_one_cycle", tx_start, 0);
        c0 = n_commit;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("write_commit", write_commit, commit_exp);
        repeat (GRD - 1) tick();
        check("cur_op_guard", cur_operation, 1);
        tick();
        check("cur_op_rx", cur_operation, 0);
        check("busy_idle", busy, 0);
        tick();
        check("commit_count", n_commit - c0, {31'b0, commit_exp});
    endtask

    initial begin
        int n;
        int s0;
        int c0;

        #12;
        check("rst_cur_op", cur_operation, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_len", tx_len, 0);
        check("rst_tx_cmd", tx_cmd, 8'hfe);
        check("rst_pak_addr", pak_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_errs", {timeout_err, overrun_err, write_commit}, 0);
        check("rst_bad_cnt", bad_cmd_cnt, 0);
        reset = 1'b0;
        repeat (4) tick();
        check("no_spurious_evt", n_start + {31'b0, busy}, 0);

        // basic read-type command and turnaround latency
        s0 = n_start;
        push_exp(6'd4, 8'h01, 16'h1220);
        send(8'h01, 16'h1234);
        wait_start(n);
        check("latency_range", (n >= TURN + 1) && (n <= TURN + 3), 1);
        finish_tx(1'b0);
        check("one_start", n_start - s0, 1);

        // tx_done outside TX is ignored
        c0 = n_commit;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (2) tick();
        check("stray_done_busy", busy, 0);
        check("stray_done_commit", n_commit - c0, 0);

        // timeout path, boundary at exactly TIMEOUT_CYCLES
        c0 = n_commit;
        push_exp(6'd33, 8'h02, 16'h4560);
        send(8'h02, 16'h457f);
        wait_start(n);
        repeat (TMO) tick();
        check("timeout_not_yet", timeout_err, 0);
        check("cur_op_in_tx", cur_operation, 1);
        tick();
        check("timeout_set", timeout_err, 1);
        check("timeout_no_commit", write_commit, 0);
        repeat (GRD) tick();
        check("timeout_idle", busy, 0);
        check("timeout_rx", cur_operation, 0);
        check("timeout_commit_cnt", n_commit - c0, 0);

        // unsupported commands
        s0 = n_start;
        for (int unsigned i = 0; i < 3; i++) begin
            send(8'h55, 16'(i));
            repeat (3) begin
                tick();
                check("bad_cur_op", cur_operation, 0);
            end
            repeat (3) tick();
        end
        check("bad_cnt_3", bad_cmd_cnt, 3);
        check("bad_no_start", n_start - s0, 0);
        check("bad_len_held", tx_len, 33);
        for (int unsigned i = 0; i < 253; i++) begin
            send(8'h55, 16'h0);
            repeat (6) tick();
        end
        check("bad_cnt_sat", bad_cmd_cnt, 8'hff);
        send(8'h77, 16'h0);
        repeat (6) tick();
        check("bad_cnt_hold", bad_cmd_cnt, 8'hff);
        check("bad_no_start_all", n_start - s0, 0);

        // overrun: second toggle while in TX
        check("overrun_clear", overrun_err, 0);
        s0 = n_start;
        push_exp(6'd4, 8'h01, 16'h0000);
        send(8'h01, 16'h001f);
        wait_start(n);
        tick();
        rx_handoff = ~rx_handoff;
        repeat (4) tick();
        check("overrun_set", overrun_err, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (GRD + 8) tick();
        check("overrun_idle", busy, 0);
        check("overrun_one_start", n_start - s0, 1);

        // asynchronous reset mid-TX, then a write serviced after release
        push_exp(6'd1, 8'h03, 16'hab00);
        send(8'h03, 16'hab0f);
        wait_start(n);
        c0 = n_commit;
        repeat (2) tick();
        check("mid_tx", cur_operation, 1);
        #2 reset = 1'b1;
        #1;
        check("async_cur_op", cur_operation, 0);
        check("async_busy", busy, 0);
        check("async_tx_cmd", tx_cmd, 8'hfe);
        check("async_tx_len", tx_len, 0);
        check("async_pak_addr", pak_addr, 0);
        check("async_flags", {timeout_err, overrun_err, write_commit}, 0);
        check("async_bad_cnt", bad_cmd_cnt, 0);
        tick();
        check("rst_no_commit", n_commit - c0, 0);
        // a high handoff level at release must yield one command
        rx_handoff = 1'b1;
        cmd        = 8'h03;
        address    = 16'h8021;
        push_exp(6'd1, 8'h03, 16'h8020);
        #2 reset = 1'b0;
        wait_start(n);
        finish_tx(1'b1);
        check("post_rst_flags", {timeout_err, overrun_err}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fake_n64_cmd_sequencer.md
FAKE_N64_CMD_SEQUENCER -- requirements
Module: fake_n64_cmd_sequencer

Interface
REQ-001 Parameter TURN_CYCLES, default 16: clk cycles between command receipt and the tx start, which is the line turnaround delay.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum clk cycles spent waiting for tx_done.
REQ-003 Parameter GUARD_CYCLES, default 4: clk cycles held in tx direction after tx_done, before the line returns to rx.
REQ-004 Port clk, input, 1: the single system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: reset, asynchronous and active-high.
REQ-006 Port rx_handoff, input, 1: toggle from the receiver; each transition marks one complete command. It is asynchronous to clk.
REQ-007 Port cmd, input, 8: received command byte; stable from the rx_handoff toggle until the next command.
REQ-008 Port address, input, 16: received read/write address; bits [4:0] are the address check field.
REQ-009 Port tx_done, input, 1: one-cycle pulse from the transmitter when the response is fully sent.
REQ-010 Port cur_operation, output, 1: line direction; 0 means receive and 1 means transmit.
REQ-011 Port tx_start, output, 1: one-cycle pulse that launches the transmitter.
REQ-012 Port tx_len, output, 6: number of response bytes for the transmitter.
REQ-013 Port tx_cmd, output, 8: latched command that selects the response source.
REQ-014 Port pak_addr, output, 16: 32-byte-aligned accessory address, equal to {address[15:5], 5'b0}.
REQ-015 Port write_commit, output, 1: one-cycle pulse after a write response completes.
REQ-016 Port busy, output, 1: high in every state except IDLE.
REQ-017 Port timeout_err, output, 1: sticky flag; cleared only by reset.
REQ-018 Port overrun_err, output, 1: sticky flag; cleared only by reset.
REQ-019 Port bad_cmd_cnt, output, 8: count of unsupported commands; saturates at 8'hff.

Function
REQ-020 rx_handoff SHALL pass through a 2-flop synchronizer plus a third history flop; any XOR change between the last two stages forms a one-cycle cmd_evt.
REQ-021 State machine states: IDLE, DECODE, TURN, TX, GUARD.
REQ-022 IDLE: cur_operation=0; on cmd_evt, latch cmd into tx_cmd and latch pak_addr; go to DECODE.
REQ-023 DECODE, one cycle, selects tx_len by tx_cmd:
- 8'h00 or 8'hff gives 3.
- 8'h01 gives 4.
- 8'h02 gives 33.
- 8'h03 gives 1.
- Any other value: increment bad_cmd_cnt (saturating) and return to IDLE without transmitting.
- For supported commands, go to TURN.
REQ-024 TURN: a cycle counter loads TURN_CYCLES-1 on entry and counts down; on zero, pulse tx_start, set cur_operation=1 and go to TX.
REQ-025 tx_start SHALL assert exactly one cycle per supported command, in the cycle TURN exits.
REQ-026 TX: the counter loads TIMEOUT_CYCLES-1 on entry.
- tx_done moves the FSM to GUARD.
- If the counter reaches zero first, set timeout_err and go to GUARD.
- tx_done and timeout in the same cycle count as done; timeout_err stays unchanged.
REQ-027 GUARD: hold cur_operation=1 for GUARD_CYCLES cycles, then clear it and go to IDLE.
REQ-028 write_commit SHALL pulse on the GUARD entry cycle only when tx_cmd=8'h03 and the exit from TX was caused by tx_done, not by timeout.
REQ-029 cmd_evt in any state other than IDLE SHALL set overrun_err and be dropped; cmd_evt arriving in the same cycle that GUARD returns to IDLE is also dropped and flagged.
REQ-030 tx_done outside TX SHALL be ignored.
REQ-031 Minimum latency from cmd_evt to tx_start SHALL be TURN_CYCLES+1 clk cycles.
REQ-032 tx_len, tx_cmd and pak_addr SHALL hold their values from DECODE until the next accepted command.
REQ-033 The counter SHALL be 16 bits wide; parameter values above 65536 are illegal.

Reset
REQ-034 Reset SHALL asynchronously force the following, all from the same reset:
- state=IDLE; cur_operation=0; tx_start=0; write_commit=0.
- tx_len=0; tx_cmd=8'hfe; pak_addr=0.
- timeout_err=0; overrun_err=0; bad_cmd_cnt=0.
- Counter and synchronizer flops=0.
REQ-035 Reset during TX or GUARD SHALL immediately return the line to rx (cur_operation=0) with no write_commit pulse.
REQ-036 An rx_handoff level that differs from the synchronizer after reset release SHALL generate one cmd_evt.

Verification
REQ-037 Toggle rx_handoff with cmd=8'h01 -> tx_start pulses once, TURN_CYCLES+1 to TURN_CYCLES+3 cycles later, with tx_len=4 and cur_operation=1; after tx_done plus GUARD_CYCLES, cur_operation=0.
REQ-038 Command 8'h03 with address=16'h8021, then tx_done -> pak_addr=16'h8020, tx_len=1, and write_commit pulses exactly one cycle.
REQ-039 Command 8'h02 with tx_done never asserted -> after TIMEOUT_CYCLES, timeout_err=1, no write_commit, and the FSM returns to IDLE.
REQ-040 Command 8'h55 three times -> bad_cmd_cnt=3, no tx_start, cur_operation stays 0; 256 bad commands -> bad_cmd_cnt stays at 8'hff.
REQ-041 Second rx_handoff toggle during TX -> overrun_err=1 and only one tx_start.
REQ-042 Reset asserted mid-TX -> all outputs take reset values in the same cycle without waiting for a clk edge; a later command is serviced normally.
